axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter ADDR_W, 32, address width of command and AXI address buses.
REQ-002 Parameter PROT, 3'b000, constant value driven on AWPROT and ARPROT.
REQ-003 clk  input  1  clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  user command request.
REQ-006 cmd_ready  output  1  master idle and able to accept a command.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDR_W  transaction address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 cmd_wstrb  input  4  write byte strobes.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  read data; holds its last value after writes.
REQ-013 rsp_resp  output  2  BRESP or RRESP of the completed transaction.
REQ-014 err_count  output  8  saturating count of non-OKAY responses.
REQ-015 AW channel: outputs AWADDR[ADDR_W], AWPROT[3], AWVALID; input AWREADY.
REQ-016 W channel: outputs WDATA[32], WSTRB[4], WVALID; input WREADY.
REQ-017 B channel: inputs BRESP[2], BVALID; output BREADY.
REQ-018 AR channel: outputs ARADDR[ADDR_W], ARPROT[3], ARVALID; input ARREADY.
REQ-019 R channel: inputs RDATA[32], RRESP[2], RVALID; output RREADY.

Function
REQ-020 The FSM SHALL have states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP; all outputs are registered.
REQ-021 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, latch addr/data/strb and go to WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0); cmd_ready=0 in every other state.
REQ-022 WR_REQ: AWVALID and WVALID SHALL both assert the cycle after acceptance; each deasserts independently the cycle after its own handshake (VALID&&READY).
REQ-023 AW and W handshakes may occur in the same cycle or in either order; go to WR_RESP only once both have completed.
REQ-024 WR_RESP: BREADY=1; on BVALID, capture BRESP into rsp_resp, pulse rsp_valid for 1 cycle, drop BREADY, return to IDLE.
REQ-025 RD_REQ: ARVALID=1 until ARREADY is seen, then go to RD_RESP.
REQ-026 RD_RESP: RREADY=1; on RVALID, capture RDATA/RRESP, pulse rsp_valid, return to IDLE.
REQ-027 While VALID is high, AWADDR/WDATA/WSTRB/ARADDR SHALL stay stable until the handshake (AXI rule); VALID SHALL never depend on READY.
REQ-028 rsp_valid has no backpressure; cmd_ready SHALL re-assert the cycle after rsp_valid.
REQ-029 A slave that stalls any READY/VALID indefinitely SHALL hold the FSM in its state; the block has no timeout.
REQ-030 err_count SHALL increment on each completion with resp!=2'b00 and saturate at 8'hFF.
REQ-031 Latency with an always-ready slave that gives a same-cycle response: accept at cycle N -> rsp_valid at N+3 for writes and at N+3 for reads.

Reset
REQ-032 On rst: state=IDLE; cmd_ready=0 during reset and 1 from the first cycle after it; all VALID/READY outputs 0; rsp_valid=0, rsp_rdata=0, rsp_resp=0, err_count=0, address/data outputs 0.
REQ-033 rst asserted mid-transaction SHALL abandon the transaction with no rsp_valid pulse.

Structure
REQ-034 Response codes (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and state encodings SHALL live in shared package axi_lite_pkg.
REQ-035 Single flat module; no sub-module is required.

Verification
REQ-036 Write 0x10 <- 0xDEADBEEF, wstrb 0xF, all READY high, BRESP=00 -> AW/W handshake on the same cycle, rsp_valid one cycle, rsp_resp=00, err_count=0.
REQ-037 Write with AWREADY 3 cycles late and WREADY immediate -> WVALID drops first, AWADDR is held stable, BREADY only after both handshakes.
REQ-038 Read 0x20, ARREADY after 2 cycles, RDATA=0x12345678 with RRESP=00 after 4 more cycles -> rsp_rdata=0x12345678, cmd_ready back high one cycle later.
REQ-039 Read with RRESP=10 repeated 256 times -> err_count saturates at 0xFF.
REQ-040 rst pulsed during WR_RESP -> no rsp_valid, all VALIDs 0, IDLE afterwards; the next command completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes, FSM state
// encodings and the error-counter helpers.
package axi_lite_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4
   } state_e;

   localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

   // Any response other than OKAY is counted as an error.
   function automatic logic is_error(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master/slave views.
interface axi_lite_master_if #(
   parameter int ADDR_W = 32
);

   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;

   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;

   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;

   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master. Accepts one user command at a time,
// runs the matching write (AW+W then B) or read (AR then R) sequence and
// reports completion with a one-cycle rsp_valid pulse. Every output comes
// straight from a register; the FSM computes all next values in one
// combinational process and a single clocked process stores them.
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int         ADDR_W = 32,
   parameter logic [2:0] PROT   = 3'b000
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [3:0]        cmd_wstrb,

   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic [7:0]        err_count,

   axi_lite_master_if.master axi
);

   state_e            state_q,     state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              awvalid_q,   awvalid_d;
   logic              wvalid_q,    wvalid_d;
   logic              bready_q,    bready_d;
   logic              arvalid_q,   arvalid_d;
   logic              rready_q,    rready_d;
   logic [ADDR_W-1:0] awaddr_q,    awaddr_d;
   logic [ADDR_W-1:0] araddr_q,    araddr_d;
   logic [31:0]       wdata_q,     wdata_d;
   logic [3:0]        wstrb_q,     wstrb_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        rsp_resp_q,  rsp_resp_d;
   logic [7:0]        err_count_q, err_count_d;

   // Next-state and next-output logic for the transaction FSM.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      state_d     = state_q;
      cmd_ready_d = 1'b0;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      awaddr_d    = awaddr_q;
      araddr_d    = araddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      err_count_d = err_count_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               if (cmd_write) begin
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  araddr_d  = cmd_addr;
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end else begin
               // Also covers the completion cycle: ready rises one cycle
               // after rsp_valid because cmd_ready_q is still low here.
               cmd_ready_d = 1'b1;
            end
         end

         WR_REQ: begin
            // AW and W retire independently; move on once both are gone.
            if (awvalid_q && axi.awready) awvalid_d = 1'b0;
            if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end

         WR_RESP: begin
            if (axi.bvalid) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = axi.bresp;
               state_d     = IDLE;
            end
         end

         RD_REQ: begin
            if (axi.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_RESP;
            end
         end

         RD_RESP: begin
            if (axi.rvalid) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = axi.rdata;
               rsp_resp_d  = axi.rresp;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      // Saturating error counter, bumped on the completing cycle only.
      if (rsp_valid_d && is_error(rsp_resp_d) && (err_count_q != ERR_COUNT_MAX))
         err_count_d = err_count_q + 8'd1;
   end

   // State and output registers; synchronous reset abandons any transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         awaddr_q    <= awaddr_d;
         araddr_q    <= araddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         err_count_q <= err_count_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_resp    = rsp_resp_q;
   assign err_count   = err_count_q;

   assign axi.awaddr  = awaddr_q;
   assign axi.awprot  = PROT;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;
   assign axi.araddr  = araddr_q;
   assign axi.arprot  = PROT;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a configurable-delay slave model,
// a protocol monitor, and hand-computed expectations per transaction.
module tb_axi_lite_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr  = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  err_count;

   axi_lite_master_if #(.ADDR_W(32)) axi ();

   axi_lite_master #(.ADDR_W(32), .PROT(3'b000)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_wstrb (cmd_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .err_count (err_count),
      .axi       (axi)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave configuration: READY/VALID delays in cycles and response payloads.
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [31:0] rdata_cfg = '0;

   // Slave model, driven on the falling edge.
   initial begin
      int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
      forever begin
         @(negedge clk);
         if (axi.awvalid) begin axi.awready = (aw_cnt >= aw_delay); aw_cnt++; end
         else begin axi.awready = 1'b0; aw_cnt = 0; end
         if (axi.wvalid) begin axi.wready = (w_cnt >= w_delay); w_cnt++; end
         else begin axi.wready = 1'b0; w_cnt = 0; end
         if (axi.bready) begin axi.bvalid = (b_cnt >= b_delay); axi.bresp = bresp_cfg; b_cnt++; end
         else begin axi.bvalid = 1'b0; b_cnt = 0; end
         if (axi.arvalid) begin axi.arready = (ar_cnt >= ar_delay); ar_cnt++; end
         else begin axi.arready = 1'b0; ar_cnt = 0; end
         if (axi.rready) begin
            axi.rvalid = (r_cnt >= r_delay); axi.rdata = rdata_cfg; axi.rresp = rresp_cfg; r_cnt++;
         end else begin axi.rvalid = 1'b0; r_cnt = 0; end
      end
   end

   // Protocol monitor: samples each cycle's settled values just after the
   // falling edge, records event times and counts AXI rule violations.
   int nc = 0, aw_last = 0, w_last = 0, b_rise = 0, rsp_cnt = 0, viol = 0;
   initial begin
      logic p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_br;
      logic [31:0] p_awaddr, p_wdata, p_araddr;
      logic [3:0]  p_wstrb;
      p_rst = 1'b1; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_br = 0;
      p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
      forever begin
         @(negedge clk);
         #1;
         nc++;
         if (axi.awvalid) aw_last = nc;
         if (axi.wvalid)  w_last  = nc;
         if (axi.bready && !p_br) b_rise = nc;
         if (rsp_valid) rsp_cnt++;
         if (!rst && !p_rst) begin
            if (p_awv && !p_awr && (!axi.awvalid || axi.awaddr != p_awaddr)) viol++;
            if (p_wv && !p_wr && (!axi.wvalid || axi.wdata != p_wdata || axi.wstrb != p_wstrb)) viol++;
            if (p_arv && !p_arr && (!axi.arvalid || axi.araddr != p_araddr)) viol++;
            if (axi.bready && (axi.awvalid || axi.wvalid)) viol++;
         end
         p_rst = rst; p_awv = axi.awvalid; p_awr = axi.awready; p_wv = axi.wvalid;
         p_wr = axi.wready; p_arv = axi.arvalid; p_arr = axi.arready; p_br = axi.bready;
         p_awaddr = axi.awaddr; p_wdata = axi.wdata; p_wstrb = axi.wstrb; p_araddr = axi.araddr;
      end
   end

   // Present a command and return on the falling edge of the cycle after acceptance.
   task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
      int n;
      n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      check("accept_timeout", 32'(n >= 50), 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0; cmd_addr = '1; cmd_wdata = '1; cmd_wstrb = '1;
   endtask

   // Wait for rsp_valid; lat counts cycles from acceptance (N) to the pulse.
   task automatic wait_rsp(output int lat, output logic [1:0] resp, output logic [31:0] rdata,
                           output logic [7:0] errc, output logic rdy_during,
                           output logic vld_after, output logic rdy_after);
      lat = 1;
      while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
      check("rsp_timeout", 32'(lat >= 200), 32'd0);
      resp = rsp_resp; rdata = rsp_rdata; errc = err_count; rdy_during = cmd_ready;
      @(negedge clk);
      vld_after = rsp_valid; rdy_after = cmd_ready;
   endtask

   initial begin
      int          lat, n;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic [7:0]  errc;
      logic        rdy_during, vld_after, rdy_after;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}), 32'd0);
      check("rst_rsp", 32'({rsp_rdata, rsp_resp, err_count}), 32'd0);
      check("rst_addr", axi.awaddr | axi.araddr | axi.wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);

      // Write, always-ready slave, OKAY.
      start_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      wait_rsp(lat, resp, rdata, errc, rdy_during, vld_after, rdy_after);
      check("wr1_latency", 32'(lat), 32'd3);
      check("wr1_resp", 32'(resp), 32'd0);
      check("wr1_err", 32'(errc), 32'd0);
      check("wr1_aw_w_same", 32'(aw_last - w_last), 32'd0);
      check("wr1_ready_during", 32'(rdy_during), 32'd0);
      check("wr1_pulse_width", 32'(vld_after), 32'd0);
      check("wr1_ready_after", 32'(rdy_after), 32'd1);
      check("wr1_awaddr", axi.awaddr, 32'h10);
      check("wr1_wdata", axi.wdata, 32'hDEAD_BEEF);
      check("wr1_wstrb", 32'(axi.wstrb), 32'hF);
      check("wr1_rdata_hold", rdata, 32'd0);

      // Write with AWREADY three cycles late: W retires first.
      aw_delay = 3;
      start_cmd(1'b1, 32'h44, 32'hCAFE_F00D, 4'b0011);
      wait_rsp(lat, resp, rdata, errc, rdy_during, vld_after, rdy_after);
      check("wr2_latency", 32'(lat), 32'd6);
      check("wr2_w_before_aw", 32'(aw_last - w_last), 32'd3);
      check("wr2_bready_after_both", 32'(b_rise - aw_last), 32'd1);
      check("wr2_awaddr", axi.awaddr, 32'h44);
      check("wr2_wstrb", 32'(axi.wstrb), 32'h3);
      aw_delay = 0;

      // Read 0x20 with ARREADY after 2 cycles, RVALID 4 cycles into RREADY.
      ar_delay = 2; r_delay = 4; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b00;
      start_cmd(1'b0, 32'h20, 32'h0, 4'h0);
      wait_rsp(lat, resp, rdata, errc, rdy_during, vld_after, rdy_after);
      check("rd1_latency", 32'(lat), 32'd9);
      check("rd1_rdata", rdata, 32'h1234_5678);
      check("rd1_resp", 32'(resp), 32'd0);
      check("rd1_ready_after", 32'(rdy_after), 32'd1);
      check("rd1_araddr", axi.araddr, 32'h20);
      ar_delay = 0; r_delay = 0;

      // Write returning DECERR: counted, read data untouched.
      bresp_cfg = 2'b11;
      start_cmd(1'b1, 32'h80, 32'h0BAD_0BAD, 4'h1);
      wait_rsp(lat, resp, rdata, errc, rdy_during, vld_after, rdy_after);
      check("wr3_resp", 32'(resp), 32'd3);
      check("wr3_err", 32'(errc), 32'd1);
      check("wr3_rdata_hold", rdata, 32'h1234_5678);
      bresp_cfg = 2'b00;

      // 256 reads with SLVERR: counter climbs then saturates.
      rresp_cfg = 2'b10; rdata_cfg = 32'h5555_AAAA;
      for (int i = 0; i < 256; i++) begin
         start_cmd(1'b0, 32'h100 + 32'(i), 32'h0, 4'h0);
         wait_rsp(lat, resp, rdata, errc, rdy_during, vld_after, rdy_after);
         if (i == 0) check("rd_fast_latency", 32'(lat), 32'd3);
         if (i == 199) check("err_count_201", 32'(errc), 32'd201);
      end
      check("err_saturated", 32'(err_count), 32'hFF);
      check("rd_slverr_resp", 32'(rsp_resp), 32'd2);
      rresp_cfg = 2'b00;

      // Reset while waiting in WR_RESP: no completion, clean restart.
      b_delay = 50;
      start_cmd(1'b1, 32'h200, 32'h1111_2222, 4'hF);
      n = 0;
      while (!axi.bready && n < 20) begin @(negedge clk); n++; end
      check("wr_resp_reached", 32'(axi.bready), 32'd1);
      rst = 1'b1;
      lat = rsp_cnt;
      @(negedge clk);
      check("mid_rst_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}), 32'd0);
      check("mid_rst_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b0; b_delay = 0;
      @(negedge clk);
      check("mid_rst_ready_after", 32'(cmd_ready), 32'd1);
      check("mid_rst_err", 32'(err_count), 32'd0);
      check("mid_rst_no_rsp", 32'(rsp_cnt - lat), 32'd0);
      start_cmd(1'b1, 32'h300, 32'h3333_4444, 4'hC);
      wait_rsp(lat, resp, rdata, errc, rdy_during, vld_after, rdy_after);
      check("after_rst_latency", 32'(lat), 32'd3);
      check("after_rst_resp", 32'(resp), 32'd0);

      check("protocol_violations", 32'(viol), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
